// File: rtl/gcd_pkg.sv
// Shared types and helpers for the GCD job scheduler.
// Scheduler FSM encoding, default data width and id-width helper.
package gcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } sched_state_e;

  localparam int GCD_DATA_W = 32;

  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/gcd_rr_pick.sv
// Combinational round-robin picker: first asserted request at or after rr_ptr,
// wrapping modulo NUM_REQ. Returns one-hot grant, its index and an any flag.
module gcd_rr_pick
  import gcd_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = id_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    rr_ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    idx,
  output logic               any
);

  int j;

  // Walk from the farthest offset down so the closest request to rr_ptr wins.
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    j     = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      j = (int'(rr_ptr) + k) % NUM_REQ;
      if (req[j]) begin
        grant    = '0;
        grant[j] = 1'b1;
        idx      = ID_W'(j);
        any      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/gcd_job_scheduler.sv
// Round-robin scheduler sharing one external iterative GCD engine among NUM_REQ requesters.
// Optional engine watchdog enabled by defining GCD_SCHED_TIMEOUT_EN.
//
// Handshakes: a transfer happens on a rising ACLK edge where valid and ready are both 1;
// valid never waits for ready, and once rsp_valid is raised rsp_id/rsp_gcd/rsp_err hold until taken.
module gcd_job_scheduler
  import gcd_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int DATA_W         = GCD_DATA_W,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                        ACLK,
  input  logic                        ARESETN,
  input  logic [NUM_REQ-1:0]          req_valid,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic [NUM_REQ*DATA_W-1:0]   req_a,
  input  logic [NUM_REQ*DATA_W-1:0]   req_b,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic [$clog2(NUM_REQ)-1:0]  rsp_id,
  output logic [DATA_W-1:0]           rsp_gcd,
  output logic                        rsp_err,
  output logic                        busy,
  output logic                        eng_start,
  output logic [DATA_W-1:0]           eng_a,
  output logic [DATA_W-1:0]           eng_b,
  input  logic                        eng_done,
  input  logic [DATA_W-1:0]           eng_result,
  output sched_state_e                dbg_state
);

  localparam int ID_W = id_w(NUM_REQ);

  sched_state_e        state, state_nxt;
  logic [ID_W-1:0]     rr_ptr, cap_id, pick_idx;
  logic [NUM_REQ-1:0]  pick_grant;
  logic                pick_any;
  logic [DATA_W-1:0]   cap_a, cap_b, res_gcd, sel_a, sel_b;
  logic                res_err, zero_op, timed_out;

  gcd_rr_pick #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_pick (
    .req    (req_valid),
    .rr_ptr (rr_ptr),
    .grant  (pick_grant),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_idx == ID_W'(i)) begin
        sel_a = req_a[i*DATA_W +: DATA_W];
        sel_b = req_b[i*DATA_W +: DATA_W];
      end
    end
  end

  // A zero operand has a trivial gcd (a|b), so the engine is skipped entirely.
  assign zero_op = (sel_a == '0) || (sel_b == '0);

`ifdef GCD_SCHED_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_cnt;

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN)            tmo_cnt <= '0;
    else if (state == ISSUE) tmo_cnt <= '0;
    else if (state == WAIT)  tmo_cnt <= tmo_cnt + TMO_W'(1);
  end

  // The last permitted WAIT cycle without done aborts the job.
  assign timed_out = (state == WAIT) && !eng_done &&
                     (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
`else
  assign timed_out = 1'b0;
`endif

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (pick_any) state_nxt = zero_op ? RESP : ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (eng_done || timed_out) state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      cap_a   <= '0;
      cap_b   <= '0;
      cap_id  <= '0;
      res_gcd <= '0;
      res_err <= 1'b0;
      rr_ptr  <= '0;
    end else begin
      unique case (state)
        IDLE: if (pick_any) begin
          cap_a  <= sel_a;
          cap_b  <= sel_b;
          cap_id <= pick_idx;
          if (zero_op) begin
            res_gcd <= sel_a | sel_b;
            res_err <= 1'b0;
          end
        end
        WAIT: if (eng_done) begin
          res_gcd <= eng_result;
          res_err <= 1'b0;
        end else if (timed_out) begin
          res_gcd <= '0;
          res_err <= 1'b1;
        end
        RESP: if (rsp_ready) begin
          rr_ptr <= (cap_id == ID_W'(NUM_REQ - 1)) ? '0 : cap_id + ID_W'(1);
        end
        default: ;
      endcase
    end
  end

  // Grants are gated by reset so every output reads 0 while ARESETN is low.
  always_comb begin
    req_ready = '0;
    if (state == IDLE && ARESETN) req_ready = pick_grant;
    rsp_valid = (state == RESP);
    busy      = (state != IDLE);
    eng_start = (state == ISSUE);
  end

  assign rsp_id    = cap_id;
  assign rsp_gcd   = res_gcd;
  assign rsp_err   = res_err;
  assign eng_a     = cap_a;
  assign eng_b     = cap_b;
  assign dbg_state = state;

endmodule

// File: tb/tb_gcd_job_scheduler.sv
// Self-checking bench for gcd_job_scheduler: behavioural engine, round-robin
// reference model over per-requester job queues, and an expected-response queue.
module tb_gcd_job_scheduler;
  import gcd_pkg::*;

  localparam int N   = 4;
  localparam int DW  = 32;
  localparam int TMO = 16;
`ifdef GCD_SCHED_TIMEOUT_EN
  localparam bit TMO_ON = 1'b1;
`else
  localparam bit TMO_ON = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic ACLK = 1'b0;
  logic ARESETN = 1'b0;
  always #5 ACLK = ~ACLK;

  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_ready;
  logic [N*DW-1:0] req_a = '0, req_b = '0;
  logic            rsp_valid, rsp_ready = 1'b0;
  logic [1:0]      rsp_id;
  logic [DW-1:0]   rsp_gcd, eng_a, eng_b, eng_result;
  logic            rsp_err, busy, eng_start, eng_done;
  sched_state_e    dbg_state;

  gcd_job_scheduler #(.NUM_REQ(N), .DATA_W(DW), .TIMEOUT_CYCLES(TMO)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_gcd(rsp_gcd), .rsp_err(rsp_err), .busy(busy),
    .eng_start(eng_start), .eng_a(eng_a), .eng_b(eng_b),
    .eng_done(eng_done), .eng_result(eng_result), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int n_tests = 0, n_fail = 0;
  logic [DW-1:0] job_a_q[N][$];
  logic [DW-1:0] job_b_q[N][$];
  logic [39:0]   exp_q[$];        // {err, id[6:0], gcd[31:0]}
  int grant_log[$];
  int model_rr = 0;
  int cyc = 0;
  bit engine_on = 1'b1, stray_req = 1'b0, rand_rdy = 1'b0, rsp_man = 1'b1;
  int hs_cyc, done_cyc;
  bit exp_bypass, exp_tmo, start_seen, rsp_seen;
  logic [DW-1:0] exp_a, exp_b, last_gcd;
  logic last_err;
  logic [34:0] held;
  int hold_err_cnt = 0, ready_err_cnt = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] ref_gcd(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [DW-1:0] t;
    while (b != 0) begin
      t = a % b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  function automatic int pending();
    int s = 0;
    for (int i = 0; i < N; i++) s += job_a_q[i].size();
    return s;
  endfunction

  initial forever begin
    @(posedge ACLK);
    cyc++;
  end

  // ---------------- behavioural engine ----------------
  initial begin
    int k;
    logic [DW-1:0] r;
    eng_done = 1'b0;
    eng_result = '0;
    forever begin
      @(negedge ACLK);
      if (stray_req || (ARESETN && eng_start && engine_on)) begin
        k = stray_req ? 1 : $urandom_range(1, 6);
        r = stray_req ? 32'd99 : ref_gcd(eng_a, eng_b);
        stray_req = 1'b0;
        repeat (k) @(posedge ACLK);
        #1 eng_done = 1'b1;
        eng_result = r;
        @(posedge ACLK);
        #1 eng_done = 1'b0;
        eng_result = $urandom;
      end
    end
  end

  // ---------------- monitor (negedge) + requester driver (posedge+1) ----------------
  initial begin
    int pred, got, j;
    logic [39:0] e;
    bit [N-1:0] pop_req;
    pop_req = '0;
    forever begin
      @(negedge ACLK);
      if (ARESETN) begin
        if (busy && req_ready != '0) ready_err_cnt++;
        if ($countones(req_ready) > 1) ready_err_cnt++;
        if ((req_valid & req_ready) != '0) begin
          pred = -1;
          got = -1;
          for (int k = 0; k < N; k++) begin
            j = (model_rr + k) % N;
            if (req_valid[j] && pred < 0) pred = j;
          end
          for (int i = 0; i < N; i++) if (req_valid[i] && req_ready[i]) got = i;
          check("grant_id", got, pred);
          exp_a = job_a_q[got][0];
          exp_b = job_b_q[got][0];
          exp_bypass = (exp_a == 0) || (exp_b == 0);
          exp_tmo = !exp_bypass && !engine_on;
          exp_q.push_back({exp_tmo, 7'(got), exp_tmo ? 32'd0 : ref_gcd(exp_a, exp_b)});
          grant_log.push_back(got);
          pop_req[got] = 1'b1;
          hs_cyc = cyc;
          start_seen = 1'b0;
        end
        if (eng_start) begin
          check("start_lat", cyc - hs_cyc, 1);
          check("eng_a", eng_a, exp_a);
          check("eng_b", eng_b, exp_b);
          start_seen = 1'b1;
        end
        if (eng_done) done_cyc = cyc;
        if (rsp_valid && !rsp_seen) begin
          rsp_seen = 1'b1;
          held = {rsp_err, rsp_id, rsp_gcd};
          check("engine_used", start_seen, !exp_bypass);
          if (exp_bypass)   check("bypass_lat", cyc - hs_cyc, 1);
          else if (exp_tmo) check("tmo_lat", cyc - hs_cyc, TMO + 2);
          else              check("done_lat", cyc - done_cyc, 1);
        end else if (rsp_valid && held != {rsp_err, rsp_id, rsp_gcd}) begin
          hold_err_cnt++;
        end
        if (rsp_valid && rsp_ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_rsp", 1, 0);
          end else begin
            e = exp_q.pop_front();
            check("rsp_id", rsp_id, e[38:32]);
            check("rsp_gcd", rsp_gcd, e[31:0]);
            check("rsp_err", rsp_err, e[39]);
            model_rr = (int'(e[38:32]) + 1) % N;
          end
          last_gcd = rsp_gcd;
          last_err = rsp_err;
          rsp_seen = 1'b0;
        end
      end
      @(posedge ACLK);
      #1;
      for (int i = 0; i < N; i++) begin
        if (pop_req[i] && job_a_q[i].size() > 0) begin
          void'(job_a_q[i].pop_front());
          void'(job_b_q[i].pop_front());
        end
        pop_req[i] = 1'b0;
        req_valid[i] = (job_a_q[i].size() > 0);
        req_a[i*DW +: DW] = req_valid[i] ? job_a_q[i][0] : $urandom;
        req_b[i*DW +: DW] = req_valid[i] ? job_b_q[i][0] : $urandom;
      end
      rsp_ready = rand_rdy ? 1'($urandom_range(0, 1)) : rsp_man;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_job(input int r, input logic [DW-1:0] a, input logic [DW-1:0] b);
    job_a_q[r].push_back(a);
    job_b_q[r].push_back(b);
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int n = 0;
    @(negedge ACLK);
    while ((exp_q.size() != 0 || pending() != 0 || busy) && n < budget) begin
      @(negedge ACLK);
      n++;
    end
    check(tag, n < budget, 1);
  endtask

  task automatic wait_rsp_valid(input int budget);
    int n = 0;
    while (!rsp_valid && n < budget) begin
      @(negedge ACLK);
      n++;
    end
    check("rsp_valid_wait", n < budget, 1);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int fair_exp[6];
    logic [DW-1:0] g;
    fair_exp = '{0, 1, 2, 0, 1, 2};

    #2;
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_req_ready", req_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_eng_start", eng_start, 0);
    check("rst_rsp_gcd", rsp_gcd, 0);
    check("rst_rsp_err", rsp_err, 0);
    check("rst_eng_a", eng_a, 0);
    check("rst_state", dbg_state, IDLE);
    repeat (3) @(negedge ACLK);
    ARESETN = 1'b1;

    // fairness from rr_ptr = 0
    grant_log.delete();
    for (int r = 0; r < 3; r++)
      for (int k = 0; k < 3; k++) push_job(r, 32'($urandom_range(1, 500)), 32'($urandom_range(1, 500)));
    wait_drain("drain_fair", 500);
    check("fair_count", grant_log.size(), 9);
    for (int i = 0; i < 6; i++) check("fair_order", grant_log[i], fair_exp[i]);

    // single job
    push_job(0, 32'd48, 32'd18);
    wait_drain("drain_single", 200);
    check("single_gcd", last_gcd, 6);

    // zero-operand bypass
    push_job(3, 32'd0, 32'd35);
    wait_drain("drain_zero1", 200);
    check("zero_gcd_35", last_gcd, 35);
    push_job(3, 32'd0, 32'd0);
    wait_drain("drain_zero2", 200);
    check("zero_gcd_0", last_gcd, 0);

    // backpressure
    rsp_man = 1'b0;
    push_job(1, 32'd21, 32'd14);
    push_job(2, 32'd9, 32'd6);
    @(negedge ACLK);
    wait_rsp_valid(200);
    repeat (10) @(negedge ACLK);
    check("bp_valid_held", rsp_valid, 1);
    check("bp_no_grant", req_ready, 0);
    rsp_man = 1'b1;
    wait_drain("drain_bp", 300);

    // randomized traffic
    rand_rdy = 1'b1;
    for (int n = 0; n < 40; n++) begin
      g = 32'($urandom_range(1, 50));
      if ($urandom_range(0, 9) == 0) push_job($urandom_range(0, N-1), 0, g * 32'($urandom_range(0, 3)));
      else push_job($urandom_range(0, N-1), g * 32'($urandom_range(1, 200)), g * 32'($urandom_range(1, 200)));
    end
    wait_drain("drain_rand", 6000);
    rand_rdy = 1'b0;

    // stray done while idle
    stray_req = 1'b1;
    repeat (5) @(negedge ACLK);
    check("stray_busy", busy, 0);
    check("stray_rsp_valid", rsp_valid, 0);

    // engine never answers
    engine_on = 1'b0;
    push_job(2, 32'd12, 32'd8);
    if (TMO_ON) begin
      wait_drain("drain_tmo", 200);
      check("tmo_err", last_err, 1);
      check("tmo_gcd", last_gcd, 0);
      stray_req = 1'b1;
      repeat (5) @(negedge ACLK);
      check("late_done_busy", busy, 0);
      push_job(1, 32'd30, 32'd20);
      repeat (6) @(negedge ACLK);
    end else begin
      repeat (60) @(negedge ACLK);
      check("hang_busy", busy, 1);
      check("hang_rsp_valid", rsp_valid, 0);
    end

    // reset in the middle of WAIT
    check("pre_reset_state", dbg_state, WAIT);
    ARESETN = 1'b0;
    #1;
    check("mid_rst_rsp_valid", rsp_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_eng_start", eng_start, 0);
    check("mid_rst_eng_a", eng_a, 0);
    check("mid_rst_rsp_gcd", rsp_gcd, 0);
    for (int i = 0; i < N; i++) begin
      job_a_q[i].delete();
      job_b_q[i].delete();
    end
    exp_q.delete();
    model_rr = 0;
    rsp_seen = 1'b0;
    engine_on = 1'b1;
    repeat (3) @(negedge ACLK);
    ARESETN = 1'b1;
    grant_log.delete();
    push_job(3, 32'd100, 32'd75);
    push_job(0, 32'd100, 32'd75);
    wait_drain("drain_post_rst", 300);
    check("post_rst_first_id", grant_log.size() > 0 ? grant_log[0] : -1, 0);
    check("post_rst_gcd", last_gcd, 25);

    check("rsp_hold_violations", hold_err_cnt, 0);
    check("ready_violations", ready_err_cnt, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "time limit");
  end

endmodule
